// File: rtl/zynq_pkg.sv
// rtl/zynq_pkg.sv - shared widths, command layout and state encoding for the bsg_tag transmitter
package zynq_pkg;

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int tag_els_gp               = 16;
    localparam int tag_max_payload_width_gp = 1;
    localparam int tag_lg_els_gp            = safe_clog2(tag_els_gp);
    localparam int tag_lg_width_gp          = safe_clog2(tag_max_payload_width_gp + 1);

    typedef struct packed {
        logic                                master_reset;
        logic [tag_lg_els_gp-1:0]            node_id;
        logic                                data_not_reset;
        logic [tag_lg_width_gp-1:0]          len;
        logic [tag_max_payload_width_gp-1:0] payload;
    } zynq_tag_cmd_s;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_ONES,
        ST_START,
        ST_LEN,
        ST_DNR,
        ST_ID,
        ST_PAYLOAD,
        ST_GAP
    } zynq_tag_state_e;

endpackage

// File: rtl/zynq_tag_tx.sv
// rtl/zynq_tag_tx.sv - serialises one tag command per handshake onto the bsg_tag data line
module zynq_tag_tx
    import zynq_pkg::*;
#(
    parameter int tag_els_p               = tag_els_gp,
    parameter int tag_max_payload_width_p = tag_max_payload_width_gp,
    parameter int gap_p                   = 2,
    parameter int reset_ones_p            = 32,
    localparam int lg_els                 = safe_clog2(tag_els_p),
    localparam int lg_width               = safe_clog2(tag_max_payload_width_p + 1)
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic                               v_i,
    output logic                               ready_and_o,
    input  logic                               master_reset_i,
    input  logic [lg_els-1:0]                  node_id_i,
    input  logic                               data_not_reset_i,
    input  logic [lg_width-1:0]                len_i,
    input  logic [tag_max_payload_width_p-1:0] payload_i,
    output logic                               tag_data_o,
    output logic                               busy_o
);

    localparam int m0      = (lg_width > lg_els) ? lg_width : lg_els;
    localparam int m1      = (m0 > tag_max_payload_width_p) ? m0 : tag_max_payload_width_p;
    localparam int m2      = (m1 > reset_ones_p) ? m1 : reset_ones_p;
    localparam int cnt_max = (m2 > gap_p) ? m2 : gap_p;
    localparam int cnt_w   = safe_clog2(cnt_max);
    localparam int sh_w    = m1;
    localparam int id_w    = tag_lg_els_gp;
    localparam int len_w   = tag_lg_width_gp;
    localparam int pay_w   = tag_max_payload_width_gp;

    zynq_tag_state_e   state_q, state_d;
    logic [cnt_w-1:0]  cnt_q, cnt_d;
    logic [sh_w-1:0]   sh_q, sh_d;
    logic              tag_q, tag_d;
    zynq_tag_cmd_s     cmd_q, cmd_d;
    logic              to_gap;
    logic [lg_width-1:0] len_sat;

    always_comb begin
        len_sat = (32'(len_i) > 32'(tag_max_payload_width_p))
                ? lg_width'(tag_max_payload_width_p) : len_i;
    end

    // tag_d is the bit for the cycle after this edge, so every state entry
    // also loads its first output bit and the remaining bits into sh_q.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        tag_d   = 1'b0;
        cmd_d   = cmd_q;
        to_gap  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (v_i) begin
                    cmd_d.master_reset   = master_reset_i;
                    cmd_d.node_id        = id_w'(node_id_i);
                    cmd_d.data_not_reset = data_not_reset_i;
                    cmd_d.len            = len_w'(len_sat);
                    cmd_d.payload        = pay_w'(payload_i);
                    tag_d                = 1'b1;
                    if (master_reset_i) begin
                        state_d = ST_RST_ONES;
                        cnt_d   = cnt_w'(reset_ones_p - 1);
                    end else begin
                        state_d = ST_START;
                        cnt_d   = '0;
                    end
                end
            end
            ST_RST_ONES: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - cnt_w'(1);
                    tag_d = cmd_q.master_reset;
                end else begin
                    to_gap = 1'b1;
                end
            end
            ST_START: begin
                state_d = ST_LEN;
                cnt_d   = cnt_w'(lg_width - 1);
                tag_d   = cmd_q.len[0];
                sh_d    = sh_w'(cmd_q.len) >> 1;
            end
            ST_LEN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - cnt_w'(1);
                    tag_d = sh_q[0];
                    sh_d  = sh_q >> 1;
                end else begin
                    state_d = ST_DNR;
                    tag_d   = cmd_q.data_not_reset;
                end
            end
            ST_DNR: begin
                state_d = ST_ID;
                cnt_d   = cnt_w'(lg_els - 1);
                tag_d   = cmd_q.node_id[0];
                sh_d    = sh_w'(cmd_q.node_id) >> 1;
            end
            ST_ID: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - cnt_w'(1);
                    tag_d = sh_q[0];
                    sh_d  = sh_q >> 1;
                end else if (cmd_q.len != '0) begin
                    state_d = ST_PAYLOAD;
                    cnt_d   = cnt_w'(cmd_q.len) - cnt_w'(1);
                    tag_d   = cmd_q.payload[0];
                    sh_d    = sh_w'(cmd_q.payload) >> 1;
                end else begin
                    to_gap = 1'b1;
                end
            end
            ST_PAYLOAD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - cnt_w'(1);
                    tag_d = sh_q[0];
                    sh_d  = sh_q >> 1;
                end else begin
                    to_gap = 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - cnt_w'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (to_gap) begin
            if (gap_p > 0) begin
                state_d = ST_GAP;
                cnt_d   = cnt_w'(gap_p - 1);
            end else begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            tag_q   <= 1'b0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            tag_q   <= tag_d;
            cmd_q   <= cmd_d;
        end
    end

    assign tag_data_o  = tag_q;
    assign ready_and_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_zynq_tag_tx.sv
// tb/tb_zynq_tag_tx.sv - directed bench with a packet-level bit-queue model of the tag stream
module tb_zynq_tag_tx;
    import zynq_pkg::*;

    localparam int LG_ELS = 4;
    localparam int LG_W   = 1;
    localparam int MAXP   = 1;
    localparam int GAP    = 2;
    localparam int RONES  = 32;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       v_i = 1'b0;
    logic       master_reset_i = 1'b0;
    logic       data_not_reset_i = 1'b0;
    logic [3:0] node_id_i = '0;
    logic [0:0] len_i = '0;
    logic [0:0] payload_i = '0;
    logic       ready_and_o;
    logic       tag_data_o;
    logic       busy_o;

    zynq_tag_tx dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .v_i              (v_i),
        .ready_and_o      (ready_and_o),
        .master_reset_i   (master_reset_i),
        .node_id_i        (node_id_i),
        .data_not_reset_i (data_not_reset_i),
        .len_i            (len_i),
        .payload_i        (payload_i),
        .tag_data_o       (tag_data_o),
        .busy_o           (busy_o)
    );

    always #5 aclk = ~aclk;

    typedef bit bitq_t[$];

    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    hs_n = 0;
    int    hs_t[$];
    bitq_t exp_q;
    bitq_t new_pkt;
    bit    exp_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wire image of one command: START, LEN, DNR, ID, PAYLOAD, then the idle gap.
    function automatic bitq_t model_pkt(input bit mr, input int id, input bit dnr,
                                        input int len, input int pay);
        bitq_t q;
        int    l;
        if (mr) begin
            for (int i = 0; i < RONES; i++) q.push_back(1'b1);
        end else begin
            l = (len > MAXP) ? MAXP : len;
            q.push_back(1'b1);
            for (int i = 0; i < LG_W; i++) q.push_back(bit'((l >> i) & 1));
            q.push_back(dnr);
            for (int i = 0; i < LG_ELS; i++) q.push_back(bit'((id >> i) & 1));
            for (int i = 0; i < l; i++) q.push_back(bit'((pay >> i) & 1));
        end
        for (int i = 0; i < GAP; i++) q.push_back(1'b0);
        return q;
    endfunction

    function automatic int pack(input bitq_t q);
        int v = 0;
        foreach (q[i]) v = (v << 1) | int'(q[i]);
        return v;
    endfunction

    always @(posedge aclk) begin
        cyc++;
        if (aresetn && v_i && ready_and_o) begin
            new_pkt = model_pkt(master_reset_i, int'(node_id_i), data_not_reset_i,
                                int'(len_i), int'(payload_i));
            foreach (new_pkt[i]) exp_q.push_back(new_pkt[i]);
            hs_t.push_back(cyc);
            hs_n++;
        end
    end

    always @(negedge aclk) begin
        if (!aresetn) begin
            exp_q.delete();
            chk("rst_tag", 32'(tag_data_o), 32'd0);
            chk("rst_ready", 32'(ready_and_o), 32'd1);
            chk("rst_busy", 32'(busy_o), 32'd0);
        end else if (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            chk("stream_bit", 32'(tag_data_o), 32'(exp_b));
            chk("busy_hi", 32'(busy_o), 32'd1);
            chk("ready_lo", 32'(ready_and_o), 32'd0);
        end else begin
            chk("idle_tag", 32'(tag_data_o), 32'd0);
            chk("idle_busy", 32'(busy_o), 32'd0);
            chk("idle_ready", 32'(ready_and_o), 32'd1);
        end
    end

    task automatic drive(input bit mr, input int id, input bit dnr, input int len, input int pay);
        master_reset_i   = mr;
        node_id_i        = 4'(id);
        data_not_reset_i = dnr;
        len_i            = 1'(len);
        payload_i        = 1'(pay);
        v_i              = 1'b1;
    endtask

    task automatic send(input bit mr, input int id, input bit dnr, input int len, input int pay,
                        output int lat, output int bz);
        int n;
        @(negedge aclk);
        drive(mr, id, dnr, len, pay);
        n = 0;
        while (!ready_and_o && n < 100) begin
            @(negedge aclk);
            n++;
        end
        chk("handshake_wait", 32'(n < 100), 32'd1);
        @(negedge aclk);
        v_i              = 1'b0;
        node_id_i        = 4'($urandom);
        data_not_reset_i = 1'($urandom);
        master_reset_i   = 1'($urandom);
        lat = 1;
        bz  = busy_o ? 1 : 0;
        while (!ready_and_o && lat < 200) begin
            @(negedge aclk);
            lat++;
            if (busy_o) bz++;
        end
        master_reset_i = 1'b0;
    endtask

    initial begin
        bitq_t tq;
        int    lat, bz, hs0, n;

        chk("model_data", 32'(pack(model_pkt(0, 3, 1, 1, 1))), 32'h3E4);
        chk("model_zero", 32'(pack(model_pkt(0, 9, 0, 0, 0))), 32'h124);
        chk("model_sat", 32'(pack(model_pkt(0, 15, 1, 1, 0))), 32'h3F8);
        tq = model_pkt(1, 0, 0, 0, 0);
        chk("model_mr_len", 32'(tq.size()), 32'd34);

        repeat (3) @(negedge aclk);
        #2 aresetn = 1'b1;
        @(negedge aclk);
        #1;
        chk("post_rst_ready", 32'(ready_and_o), 32'd1);
        chk("post_rst_tag", 32'(tag_data_o), 32'd0);

        send(0, 3, 1, 1, 1, lat, bz);
        chk("data_latency", 32'(lat), 32'd11);
        chk("data_busy", 32'(bz), 32'd10);

        send(0, 9, 0, 0, 0, lat, bz);
        chk("zero_latency", 32'(lat), 32'd10);
        chk("zero_busy", 32'(bz), 32'd9);

        send(1, 0, 0, 0, 0, lat, bz);
        chk("mr_latency", 32'(lat), 32'd35);
        chk("mr_busy", 32'(bz), 32'd34);

        send(0, 15, 1, 1, 0, lat, bz);
        chk("sat_latency", 32'(lat), 32'd11);

        hs0 = hs_n;
        @(negedge aclk);
        drive(0, 6, 1, 1, 1);
        n = 0;
        while (hs_n == hs0 && n < 50) begin
            @(negedge aclk);
            n++;
        end
        drive(0, 10, 0, 0, 0);
        n = 0;
        while (hs_n < hs0 + 2 && n < 50) begin
            @(negedge aclk);
            n++;
        end
        v_i = 1'b0;
        repeat (15) @(negedge aclk);
        chk("b2b_count", 32'(hs_n - hs0), 32'd2);
        chk("b2b_spacing", 32'(hs_t[hs0+1] - hs_t[hs0]), 32'd11);

        @(negedge aclk);
        drive(0, 3, 1, 1, 1);
        @(negedge aclk);
        v_i = 1'b0;
        repeat (3) @(negedge aclk);
        chk("pre_rst_id_bit", 32'(tag_data_o), 32'd1);
        #2 aresetn = 1'b0;
        #1;
        chk("mid_rst_tag", 32'(tag_data_o), 32'd0);
        chk("mid_rst_ready", 32'(ready_and_o), 32'd1);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        repeat (2) @(negedge aclk);
        #2 aresetn = 1'b1;

        send(0, 5, 1, 1, 1, lat, bz);
        chk("after_rst_latency", 32'(lat), 32'd11);

        repeat (4) @(negedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
